// File: rtl/alu_unit.sv
// 8-bit registered ALU: AND, XOR, logical shifts, add, optional sub; 1-cycle latency.
// Optional feature macro: ALU_SUB_EN enables OP 101 = SUB (otherwise it decodes as invalid).
module alu_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] OP,
    input  logic [7:0] R1,
    input  logic [7:0] R2,
    output logic [7:0] OUT,
    output logic [1:0] OVERFLOW,
    output logic       ZF
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_XOR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_e;

    logic [7:0]  out_d, out_q;
    logic [1:0]  ovf_d, ovf_q;
    logic        zf_d, zf_q;
    logic        big_shift;
    logic [15:0] shl_w, shr_w;
    logic [8:0]  sum_w, diff_w;

    // Shifts go through a 16-bit window so the spilled half shows which bits were lost.
    assign big_shift = |R1[7:3];
    assign shl_w     = {8'h00, R2} << R1[2:0];
    assign shr_w     = {R2, 8'h00} >> R1[2:0];
    assign sum_w     = {1'b0, R1} + {1'b0, R2};
    assign diff_w    = {1'b0, R1} - {1'b0, R2};

    always_comb begin
        out_d = 8'h00;
        ovf_d = 2'b00;
        case (op_e'(OP))
            OP_AND: out_d = R1 & R2;
            OP_XOR: out_d = R1 ^ R2;
            OP_SHL: begin
                if (big_shift) begin
                    ovf_d[1] = |R2;
                end else begin
                    out_d    = shl_w[7:0];
                    ovf_d[1] = |shl_w[15:8];
                end
            end
            OP_SHR: begin
                if (big_shift) begin
                    ovf_d[0] = |R2;
                end else begin
                    out_d    = shr_w[15:8];
                    ovf_d[0] = |shr_w[7:0];
                end
            end
            OP_ADD: begin
                out_d    = sum_w[7:0];
                ovf_d[1] = sum_w[8];
                ovf_d[0] = (R1[7] == R2[7]) && (sum_w[7] != R1[7]);
            end
`ifdef ALU_SUB_EN
            OP_SUB: begin
                out_d    = diff_w[7:0];
                ovf_d[1] = diff_w[8];
                ovf_d[0] = (R1[7] != R2[7]) && (diff_w[7] != R1[7]);
            end
`endif
            default: begin
                out_d = 8'h00;
                ovf_d = 2'b00;
            end
        endcase
        zf_d = (out_d == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 8'h00;
            ovf_q <= 2'b00;
            zf_q  <= 1'b1;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            zf_q  <= zf_d;
        end
    end

    assign OUT      = out_q;
    assign OVERFLOW = ovf_q;
    assign ZF       = zf_q;

`ifndef ALU_SUB_EN
    logic unused_diff;
    assign unused_diff = ^diff_w;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed + random scoreboard bench for alu_unit; expected results queued at drive time.
module tb_alu_unit;

    typedef struct packed {
        logic [7:0] o;
        logic [1:0] f;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] OP;
    logic [7:0] R1, R2;
    logic [7:0] OUT;
    logic [1:0] OVERFLOW;
    logic       ZF;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_unit dut (
        .clk     (clk),
        .reset   (reset),
        .OP      (OP),
        .R1      (R1),
        .R2      (R2),
        .OUT     (OUT),
        .OVERFLOW(OVERFLOW),
        .ZF      (ZF)
    );

    // Arithmetic reference built from integer math, independent of bit tricks.
    function automatic exp_t model(input logic rst, input logic [2:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   s, sa, sb, ss, ia, ib;
        e  = '{o: 8'h00, f: 2'b00, z: 1'b1};
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        if (rst) return e;
        case (op)
            3'd0: e.o = a & b;
            3'd1: e.o = a ^ b;
            3'd2: begin
                if (ia >= 8) begin
                    e.f[1] = (ib != 0);
                end else begin
                    s      = ib * (1 << ia);
                    e.o    = s[7:0];
                    e.f[1] = (s > 255);
                end
            end
            3'd3: begin
                if (ia >= 8) begin
                    e.f[0] = (ib != 0);
                end else begin
                    s      = ib / (1 << ia);
                    e.o    = s[7:0];
                    e.f[0] = ((ib % (1 << ia)) != 0);
                end
            end
            3'd4: begin
                s      = ia + ib;
                ss     = sa + sb;
                e.o    = s[7:0];
                e.f[1] = (s > 255);
                e.f[0] = (ss > 127) || (ss < -128);
            end
`ifdef ALU_SUB_EN
            3'd5: begin
                s      = ia - ib;
                ss     = sa - sb;
                e.o    = s[7:0];
                e.f[1] = (ia < ib);
                e.f[0] = (ss > 127) || (ss < -128);
            end
`endif
            default: e.o = 8'h00;
        endcase
        e.z = (e.o == 8'h00);
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        n_tests++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard empty", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            assert (OUT === e.o) else begin
                n_fail++;
                $error("FAIL %s OUT got %h want %h", tag, OUT, e.o);
            end
            n_tests++;
            assert (OVERFLOW === e.f) else begin
                n_fail++;
                $error("FAIL %s OVERFLOW got %b want %b", tag, OVERFLOW, e.f);
            end
            n_tests++;
            assert (ZF === e.z) else begin
                n_fail++;
                $error("FAIL %s ZF got %b want %b", tag, ZF, e.z);
            end
        end
    endtask

    // Drive one op with a hand-derived expectation; also cross-check the model.
    task automatic step_k(input string tag, input logic rst, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic [1:0] ef, input logic ez);
        exp_t k, m;
        k = '{o: eo, f: ef, z: ez};
        m = model(rst, op, a, b);
        n_tests++;
        assert (m === k) else begin
            n_fail++;
            $error("FAIL %s model got %h want %h", tag, m, k);
        end
        reset = rst; OP = op; R1 = a; R2 = b;
        sb_q.push_back(k);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic step_m(input string tag, input logic rst, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b);
        reset = rst; OP = op; R1 = a; R2 = b;
        sb_q.push_back(model(rst, op, a, b));
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        reset = 1'b1; OP = 3'd0; R1 = 8'h00; R2 = 8'h00;
        #1;
        step_k("reset",       1'b1, 3'd4, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        step_k("reset_prio",  1'b1, 3'd4, 8'h01, 8'h01, 8'h00, 2'b00, 1'b1);
        step_k("and",         1'b0, 3'd0, 8'hAA, 8'hCC, 8'h88, 2'b00, 1'b0);
        step_k("xor",         1'b0, 3'd1, 8'hF0, 8'hAA, 8'h5A, 2'b00, 1'b0);
        step_k("shl3",        1'b0, 3'd2, 8'd3,  8'h01, 8'h08, 2'b00, 1'b0);
        step_k("shr2",        1'b0, 3'd3, 8'd2,  8'h80, 8'h20, 2'b00, 1'b0);
        step_k("shl9",        1'b0, 3'd2, 8'd9,  8'hFF, 8'h00, 2'b10, 1'b1);
        step_k("shr_lost",    1'b0, 3'd3, 8'd1,  8'h03, 8'h01, 2'b01, 1'b0);
        step_k("shl_lost",    1'b0, 3'd2, 8'd1,  8'h81, 8'h02, 2'b10, 1'b0);
        step_k("shr200",      1'b0, 3'd3, 8'd200, 8'h10, 8'h00, 2'b01, 1'b1);
        step_k("shl0",        1'b0, 3'd2, 8'd0,  8'hC3, 8'hC3, 2'b00, 1'b0);
        step_k("shr0",        1'b0, 3'd3, 8'd0,  8'hC3, 8'hC3, 2'b00, 1'b0);
        step_k("add15_10",    1'b0, 3'd4, 8'd15, 8'd10, 8'd25, 2'b00, 1'b0);
        step_k("add255_255",  1'b0, 3'd4, 8'hFF, 8'hFF, 8'hFE, 2'b10, 1'b0);
        step_k("add127_1",    1'b0, 3'd4, 8'h7F, 8'h01, 8'h80, 2'b01, 1'b0);
        step_k("add80_80",    1'b0, 3'd4, 8'h80, 8'h80, 8'h00, 2'b11, 1'b1);
        step_k("add0_0",      1'b0, 3'd4, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        step_k("inv111",      1'b0, 3'd7, 8'hAA, 8'h55, 8'h00, 2'b00, 1'b1);
        step_k("inv110",      1'b0, 3'd6, 8'hAA, 8'h55, 8'h00, 2'b00, 1'b1);
`ifdef ALU_SUB_EN
        step_k("sub5_7",      1'b0, 3'd5, 8'd5,  8'd7,  8'hFE, 2'b10, 1'b0);
        step_k("sub80_01",    1'b0, 3'd5, 8'h80, 8'h01, 8'h7F, 2'b01, 1'b0);
`else
        step_k("op101_inv",   1'b0, 3'd5, 8'd5,  8'd7,  8'h00, 2'b00, 1'b1);
`endif
        step_k("reset_mid",   1'b1, 3'd1, 8'hFF, 8'h00, 8'h00, 2'b00, 1'b1);
        // Back-to-back random traffic, one op per cycle, reset occasionally.
        for (int i = 0; i < 200; i++) begin
            step_m("rand", ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 40; i++) begin
            step_m("rand_shift", 1'b0, 3'($urandom_range(2, 3)), 8'($urandom_range(0, 10)),
                   8'($urandom_range(0, 255)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
